// File: rtl/button_gesture.sv
// button_gesture: classifies debounced push-button activity into gestures.
//
// Consumes the level (db) and edge pulses (rise/fall) from the debounce stage
// and reports short press, double press, long press and auto-repeat ticks.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   en        block enable; low returns to IDLE on the next edge
//   db        debounced level, high = pressed
//   rise      one-cycle pulse on debounced press
//   fall      one-cycle pulse on debounced release
//   short_p   pulse: single short press completed
//   double_p  pulse: double press detected
//   long_p    pulse: long-press threshold reached
//   repeat_p  pulse: auto-repeat tick while held
//   held      level: high while in HOLD (one cycle behind the state)
//   busy      level: high while not IDLE (one cycle behind the state)
module button_gesture #(
  parameter int LONG_CYC  = 12_500_000,
  parameter int GAP_CYC   = 6_250_000,
  parameter int REP_CYC   = 2_500_000,
  parameter bit REPEAT_EN = 1'b1,
  parameter int TW        = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic db,
  input  logic rise,
  input  logic fall,
  output logic short_p,
  output logic double_p,
  output logic long_p,
  output logic repeat_p,
  output logic held,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS1   = 3'd1,
    GAP      = 3'd2,
    PRESS2   = 3'd3,
    HOLD     = 3'd4,
    WAIT_REL = 3'd5
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  // Simultaneous rise and fall cancel each other for that cycle.
  logic rise_ok, fall_ok, rel;
  logic long_hit, gap_hit, rep_hit;

  assign rise_ok  = rise & ~fall;
  assign fall_ok  = fall & ~rise;
  // A low level also counts as release so a missed fall pulse cannot
  // leave the block stuck in a pressed state.
  assign rel      = fall_ok | ~db;
  assign long_hit = (timer == TW'(LONG_CYC - 1));
  assign gap_hit  = (timer == TW'(GAP_CYC - 1));
  assign rep_hit  = (timer == TW'(REP_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      short_p  <= 1'b0;
      double_p <= 1'b0;
      long_p   <= 1'b0;
      repeat_p <= 1'b0;
      held     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      short_p  <= 1'b0;
      double_p <= 1'b0;
      long_p   <= 1'b0;
      repeat_p <= 1'b0;
      // Levels track the state of the previous cycle.
      held     <= (state == HOLD);
      busy     <= (state != IDLE);
      // Saturating count; any transition below overrides with a clear.
      if (timer != '1) timer <= timer + TW'(1);

      if (!en) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise_ok) begin
              state <= PRESS1;
              timer <= '0;
            end
          end
          PRESS1: begin
            if (rel) begin
              state <= GAP;
              timer <= '0;
            end else if (long_hit) begin
              long_p <= 1'b1;
              state  <= HOLD;
              timer  <= '0;
            end
          end
          GAP: begin
            if (rise_ok) begin
              state <= PRESS2;
              timer <= '0;
            end else if (gap_hit) begin
              short_p <= 1'b1;
              state   <= IDLE;
              timer   <= '0;
            end
          end
          PRESS2: begin
            if (rel) begin
              double_p <= 1'b1;
              state    <= IDLE;
              timer    <= '0;
            end else if (long_hit) begin
              // A long second press still counts as a double press.
              double_p <= 1'b1;
              state    <= WAIT_REL;
              timer    <= '0;
            end
          end
          HOLD: begin
            if (rel) begin
              state <= IDLE;
              timer <= '0;
            end else if (rep_hit) begin
              repeat_p <= REPEAT_EN;
              timer    <= '0;
            end
          end
          WAIT_REL: begin
            if (rel) begin
              state <= IDLE;
              timer <= '0;
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule
